branch_sequencer: RTL and testbench
===================================

# branch_sequencer

Control-step sequencer for the CPU's conditional-branch path. It walks the fetch steps T0–T2, decodes the opcode, and for branch instructions drives the condition-evaluation step that loads the CON flip-flop. It then sequences the PC-relative target computation and issues PCin only when the latched CON output is 1. It sits between the instruction register / CON logic and the datapath strobes: the register file, PC, MAR/MDR, Y/Z and ALU.

## Interface
Parameters:
- OP_BR, default 5'b10010, branch opcode (ir[31:27]).
- OP_NOP, default 5'b11010, no-operation opcode.
- OP_HALT, default 5'b11011, halt opcode.

Ports:
- clk  in  1  Single clock; every state change happens on its rising edge.
- clr_n  in  1  Reset, asynchronous and active-low.
- start  in  1  Leaves IDLE or HALTED.
- ir  in  32  Instruction register contents. Only ir[31:27] is used.
- con  in  1  Registered CON flip-flop output.
- mem_rdy  in  1  Memory read completion.
- PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin, Gra, Rout, CONin, Yin, Cout, ADD  out  1 each  Datapath strobes.
- run  out  1  High in every state except IDLE and HALTED.
- br_taken  out  1  One-cycle pulse in T6.
- illegal  out  1  One-cycle pulse in T3 when the opcode is not BR, NOP or HALT.
- step  out  4  Current state encoding: IDLE=0, T0..T6=1..7, HALTED=8.

## Operation
- The FSM is Moore except for three Mealy terms:
  - opcode-dependent outputs in T3;
  - the con-gated outputs in T4;
  - the mem_rdy-gated transition in T1.
- Any strobe not listed for a state is 0.
- IDLE: all outputs 0. If start=1, go to T0.
- T0: PCout, MARin, IncPC, Zin. Go to T1.
- T1: Zlowout, PCin, Read, MDRin, all held every cycle while waiting. If mem_rdy=1, go to T2; otherwise stay in T1.
- T2: MDRout, IRin. Go to T3. IR holds the new instruction from T3 onward.
- T3: decode ir[31:27].
  - OP_BR: assert Gra, Rout, CONin, then go to T4. The CON flip-flop captures the condition on the edge that ends T3.
  - OP_NOP: no strobes. Go to T0.
  - OP_HALT: no strobes. Go to HALTED.
  - Any other opcode: illegal=1. Go to T0.
- T4:
  - If con=1: PCout, Yin, then go to T5.
  - If con=0: no strobes, go to T0. The branch is not taken; PC already holds PC+1.
- T5: Cout, ADD, Zin. Go to T6.
- T6: Zlowout, PCin, br_taken=1. Go to T0.
- HALTED: run=0, all strobes 0. If start=1, go to T0.
- start is ignored in T0–T6.

## Timing
- Reset (clr_n=0) forces IDLE immediately, without waiting for a clock edge. While reset is held, every output is 0 and step=0.
- If reset is asserted mid-instruction, strobes drop in the same cycle. The sequencer returns to IDLE and needs start to resume; there is no partial completion.
- Release of clr_n is sampled at the next clk rising edge. start sampled on that same edge is honoured.
- Latencies, counted in clocks from entering T0 with mem_rdy already high:
  - NOP or illegal: 4 (T0–T3).
  - HALT: 4, then HALTED.
  - Branch not taken: 5 (T0–T4).
  - Branch taken: 7 (T0–T6).
- Each cycle mem_rdy is low in T1 adds exactly one cycle.
- T1 → T2 happens on the first edge where mem_rdy=1. A mem_rdy asserted outside T1 is ignored.
- con is sampled only in T4. A con change at any other time has no effect.
- The new PC from T6 is in place at the first cycle of the following T0.
- run=1 from the first T0 cycle until the edge that enters IDLE or HALTED.

## Test plan
- Reset: hold clr_n=0 for 3 cycles → all outputs 0 and step=0. Release clr_n with start=0 → remains in IDLE.
- NOP fetch: start pulse, ir=0xD000_0000, mem_rdy=1 → step sequence 1,2,3,4,1. Only the listed strobes are asserted, and illegal stays 0.
- Branch taken: ir=0x9000_0000 with con=1 in T4 → T4 asserts PCout and Yin, T5 asserts Cout, ADD and Zin, T6 asserts PCin and br_taken=1 → back to T0 after 7 cycles.
- Branch not taken: same ir with con=0 → T4 has no strobes and step goes 5→1. PCin is asserted only in T1, and br_taken never fires.
- Memory wait plus illegal opcode: mem_rdy held low for 2 cycles in T1 → step=2 for 3 cycles with Read high throughout. Then ir=0x0800_0000 → illegal pulses once in T3, followed by T0.
- HALT and reset mid-op:
  - ir=0xD800_0000 → HALTED with run=0; start returns the sequencer to T0.
  - clr_n dropped during T5 → outputs go to 0 and step=0 without waiting for a clock edge.

Source files
------------

// File: rtl/branch_sequencer.sv
// Control-step sequencer for the conditional-branch path: fetch (T0-T2), decode (T3),
// CON evaluation and PC-relative target computation (T4-T6), plus IDLE/HALTED.
module branch_sequencer #(
  parameter logic [4:0] OP_BR   = 5'b10010,
  parameter logic [4:0] OP_NOP  = 5'b11010,
  parameter logic [4:0] OP_HALT = 5'b11011
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        start,
  input  logic [31:0] ir,
  input  logic        con,
  input  logic        mem_rdy,
  output logic        PCout,
  output logic        MARin,
  output logic        IncPC,
  output logic        Zin,
  output logic        Zlowout,
  output logic        PCin,
  output logic        Read,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Gra,
  output logic        Rout,
  output logic        CONin,
  output logic        Yin,
  output logic        Cout,
  output logic        ADD,
  output logic        run,
  output logic        br_taken,
  output logic        illegal,
  output logic [3:0]  step
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    T0     = 4'd1,
    T1     = 4'd2,
    T2     = 4'd3,
    T3     = 4'd4,
    T4     = 4'd5,
    T5     = 4'd6,
    T6     = 4'd7,
    HALTED = 4'd8
  } state_e;

  state_e state_q, state_d;

  logic [4:0] opcode;
  logic       unused_ir;

  assign opcode    = ir[31:27];
  assign unused_ir = ^ir[26:0];

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Outputs decode from state_q, so an async reset drops every strobe immediately.
  always_comb begin
    state_d  = state_q;
    PCout    = 1'b0;
    MARin    = 1'b0;
    IncPC    = 1'b0;
    Zin      = 1'b0;
    Zlowout  = 1'b0;
    PCin     = 1'b0;
    Read     = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Gra      = 1'b0;
    Rout     = 1'b0;
    CONin    = 1'b0;
    Yin      = 1'b0;
    Cout     = 1'b0;
    ADD      = 1'b0;
    br_taken = 1'b0;
    illegal  = 1'b0;
    run      = (state_q != IDLE) && (state_q != HALTED);
    step     = state_q;
    case (state_q)
      IDLE, HALTED: begin
        if (start) state_d = T0;
      end
      T0: begin
        PCout   = 1'b1;
        MARin   = 1'b1;
        IncPC   = 1'b1;
        Zin     = 1'b1;
        state_d = T1;
      end
      T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        if (mem_rdy) state_d = T2;
      end
      T2: begin
        MDRout  = 1'b1;
        IRin    = 1'b1;
        state_d = T3;
      end
      T3: begin
        if (opcode == OP_BR) begin
          Gra     = 1'b1;
          Rout    = 1'b1;
          CONin   = 1'b1;
          state_d = T4;
        end else if (opcode == OP_NOP) begin
          state_d = T0;
        end else if (opcode == OP_HALT) begin
          state_d = HALTED;
        end else begin
          illegal = 1'b1;
          state_d = T0;
        end
      end
      T4: begin
        if (con) begin
          PCout   = 1'b1;
          Yin     = 1'b1;
          state_d = T5;
        end else begin
          state_d = T0;
        end
      end
      T5: begin
        Cout    = 1'b1;
        ADD     = 1'b1;
        Zin     = 1'b1;
        state_d = T6;
      end
      T6: begin
        Zlowout  = 1'b1;
        PCin     = 1'b1;
        br_taken = 1'b1;
        state_d  = T0;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_branch_sequencer.sv
// Bench for branch_sequencer: per-instruction expected cycle traces built from the
// control-step table, replayed with randomized don't-care inputs and compared each cycle.
module tb_branch_sequencer;

  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [18:0] PCOUT = 19'd1 << 0,  MARIN   = 19'd1 << 1,  INCPC = 19'd1 << 2;
  localparam logic [18:0] ZIN   = 19'd1 << 3,  ZLOWOUT = 19'd1 << 4,  PCIN  = 19'd1 << 5;
  localparam logic [18:0] READ  = 19'd1 << 6,  MDRIN   = 19'd1 << 7,  MDROUT = 19'd1 << 8;
  localparam logic [18:0] IRIN  = 19'd1 << 9,  GRA     = 19'd1 << 10, ROUT  = 19'd1 << 11;
  localparam logic [18:0] CONIN = 19'd1 << 12, YIN     = 19'd1 << 13, COUT  = 19'd1 << 14;
  localparam logic [18:0] ADDS  = 19'd1 << 15, RUN     = 19'd1 << 16, BRT   = 19'd1 << 17;
  localparam logic [18:0] ILL   = 19'd1 << 18;

  logic clk = 1'b0;
  logic clr_n, start, con, mem_rdy;
  logic [31:0] ir;
  logic PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin;
  logic Gra, Rout, CONin, Yin, Cout, ADD, run, br_taken, illegal;
  logic [3:0] step;
  logic [18:0] act;

  int unsigned tests = 0;
  int unsigned fails = 0;

  typedef struct {
    logic [3:0]  step;
    logic [18:0] outs;
    logic        rdy;
    logic        con;
    logic        start;
    logic [31:0] ir;
    string       tag;
  } cyc_t;

  cyc_t q[$];

  always #5 clk = ~clk;

  assign act = {illegal, br_taken, run, ADD, Cout, Yin, CONin, Rout, Gra, IRin,
                MDRout, MDRin, Read, PCin, Zlowout, Zin, IncPC, MARin, PCout};

  branch_sequencer #(.OP_BR(OP_BR), .OP_NOP(OP_NOP), .OP_HALT(OP_HALT)) dut (
    .clk(clk), .clr_n(clr_n), .start(start), .ir(ir), .con(con), .mem_rdy(mem_rdy),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin), .Zlowout(Zlowout),
    .PCin(PCin), .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
    .Gra(Gra), .Rout(Rout), .CONin(CONin), .Yin(Yin), .Cout(Cout), .ADD(ADD),
    .run(run), .br_taken(br_taken), .illegal(illegal), .step(step)
  );

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  task automatic check(input logic [3:0] es, input logic [18:0] eo, input string tag);
    tests++;
    assert (step === es) else begin
      fails++;
      $error("FAIL %s step: got %0d expected %0d", tag, step, es);
    end
    tests++;
    assert (act === eo) else begin
      fails++;
      $error("FAIL %s outputs: got %b expected %b", tag, act, eo);
    end
  endtask

  task automatic push(input logic [3:0] s, input logic [18:0] o, input logic r,
                      input logic c, input logic st, input logic [31:0] irv, input string tag);
    cyc_t e;
    e.step = s; e.outs = o; e.rdy = r; e.con = c; e.start = st; e.ir = irv; e.tag = tag;
    q.push_back(e);
  endtask

  // Expected trace of one instruction starting at T0; waits = cycles with mem_rdy low in T1.
  task automatic add_instr(input logic [4:0] op, input int unsigned waits, input logic cv,
                           input string tag);
    logic [31:0] irv;
    irv = {op, 27'($urandom)};
    push(4'd1, PCOUT | MARIN | INCPC | ZIN | RUN, rb(), rb(), rb(), $urandom, tag);
    for (int unsigned i = 0; i < waits; i++)
      push(4'd2, ZLOWOUT | PCIN | READ | MDRIN | RUN, 1'b0, rb(), rb(), $urandom, tag);
    push(4'd2, ZLOWOUT | PCIN | READ | MDRIN | RUN, 1'b1, rb(), rb(), $urandom, tag);
    push(4'd3, MDROUT | IRIN | RUN, rb(), rb(), rb(), $urandom, tag);
    if (op == OP_BR) begin
      push(4'd4, GRA | ROUT | CONIN | RUN, rb(), rb(), rb(), irv, tag);
      if (cv) begin
        push(4'd5, PCOUT | YIN | RUN, rb(), 1'b1, rb(), irv, tag);
        push(4'd6, COUT | ADDS | ZIN | RUN, rb(), rb(), rb(), $urandom, tag);
        push(4'd7, ZLOWOUT | PCIN | RUN | BRT, rb(), rb(), rb(), $urandom, tag);
      end else begin
        push(4'd5, RUN, rb(), 1'b0, rb(), irv, tag);
      end
    end else if (op == OP_NOP) begin
      push(4'd4, RUN, rb(), rb(), rb(), irv, tag);
    end else if (op == OP_HALT) begin
      push(4'd4, RUN, rb(), rb(), rb(), irv, tag);
      for (int unsigned i = 0; i < $urandom_range(0, 2); i++)
        push(4'd8, '0, rb(), rb(), 1'b0, $urandom, tag);
      push(4'd8, '0, rb(), rb(), 1'b1, $urandom, tag);
    end else begin
      push(4'd4, RUN | ILL, rb(), rb(), rb(), irv, tag);
    end
  endtask

  task automatic play();
    cyc_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      @(posedge clk);
      #1;
      start = e.start; mem_rdy = e.rdy; con = e.con; ir = e.ir;
      @(negedge clk);
      check(e.step, e.outs, e.tag);
    end
  endtask

  function automatic logic [4:0] rand_illegal();
    logic [4:0] op;
    do op = 5'($urandom); while (op == OP_BR || op == OP_NOP || op == OP_HALT);
    return op;
  endfunction

  initial begin
    logic [4:0] op;
    clr_n = 1'b0; start = 1'b1; con = 1'b1; mem_rdy = 1'b1; ir = 32'h9000_0000;

    // Reset held three cycles, with start asserted to show it is masked.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check(4'd0, '0, "reset_hold");
    end
    @(posedge clk); #1;
    clr_n = 1'b1; start = 1'b0;
    @(negedge clk);
    check(4'd0, '0, "reset_release");
    push(4'd0, '0, 1'b1, 1'b1, 1'b0, $urandom, "idle_no_start");
    push(4'd0, '0, rb(), rb(), 1'b1, $urandom, "idle_start");
    play();

    add_instr(OP_NOP, 0, 1'b0, "nop");
    add_instr(OP_BR, 0, 1'b1, "br_taken");
    add_instr(OP_BR, 0, 1'b0, "br_not_taken");
    add_instr(5'b00001, 2, 1'b0, "illegal_wait2");
    add_instr(OP_HALT, 0, 1'b0, "halt");
    add_instr(OP_NOP, 1, 1'b0, "nop_after_halt");
    play();

    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 4))
        0:       add_instr(OP_NOP, $urandom_range(0, 3), rb(), "rnd_nop");
        1:       add_instr(OP_HALT, $urandom_range(0, 3), rb(), "rnd_halt");
        2, 3:    add_instr(OP_BR, $urandom_range(0, 3), rb(), "rnd_br");
        default: begin
          op = rand_illegal();
          add_instr(op, $urandom_range(0, 3), rb(), "rnd_illegal");
        end
      endcase
      play();
    end

    // Reset dropped in T5 of a taken branch: T6 is never reached.
    add_instr(OP_BR, 1, 1'b1, "br_before_reset");
    void'(q.pop_back());
    play();
    clr_n = 1'b0;
    #1;
    check(4'd0, '0, "async_reset_t5");
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check(4'd0, '0, "reset_held_t5");
    @(posedge clk); #1;
    clr_n = 1'b1; start = 1'b1;
    @(negedge clk);
    check(4'd0, '0, "release_with_start");
    add_instr(OP_BR, 0, 1'b1, "br_after_reset");
    add_instr(OP_NOP, 0, 1'b0, "final_nop");
    play();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
